// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned XLen     = 64;

  // Controller sequencing state.
  typedef enum logic [1:0] {
    StRun,
    StMuldiv,
    StTrapDrain,
    StTrapFlush
  } ctrl_state_e;

  // Per-stage hold/bubble request.
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_raw_hazard_check.sv
// raw_hazard_check unit: compares one decode source register against one in-flight writer.
// x0 is never a hazard because writes to it are discarded.
module pipeline_ctrl_raw_hazard_check
  import pipeline_ctrl_pkg::*;
(
  input  logic                use_i,
  input  logic [RegAddrW-1:0] src_i,
  input  logic                wr_valid_i,
  input  logic                wr_wen_i,
  input  logic [RegAddrW-1:0] wr_dst_i,
  output logic                hit_o
);

  assign hit_o = use_i & wr_valid_i & wr_wen_i & (wr_dst_i != '0) & (src_i == wr_dst_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard / sequencing controller for the 5-stage RV64 pipeline.
// Build option: define FORWARD_EN when the bypass network exists; then only load-use
// hazards stall. Without it, any EX/MEM/WB writer matching a used source stalls decode.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_valid,
  input  logic [RegAddrW-1:0] d_ra1,
  input  logic [RegAddrW-1:0] d_ra2,
  input  logic                d_use1,
  input  logic                d_use2,
  input  logic                e_valid,
  input  logic                e_wen,
  input  logic                e_is_load,
  input  logic                e_is_mul,
  input  logic                e_is_div,
  input  logic [RegAddrW-1:0] e_dst,
  input  logic                e_br_taken,
  input  logic [XLen-1:0]     e_br_target,
  input  logic                m_valid,
  input  logic                m_wen,
  input  logic [RegAddrW-1:0] m_dst,
  input  logic                m_exception,
  input  logic                m_mret,
  input  logic [XLen-1:0]     trap_vec,
  input  logic [XLen-1:0]     mepc,
  input  logic                ibus_busy,
  input  logic                dbus_busy,
  input  logic                w_valid,
  input  logic                w_wen,
  input  logic [RegAddrW-1:0] w_dst,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                flush_d,
  output logic                flush_e,
  output logic                flush_m,
  output logic                redirect_valid,
  output logic [XLen-1:0]     redirect_pc,
  output logic                muldiv_busy
);

  localparam logic             MulLong = (MUL_LAT > 1);
  localparam logic             DivLong = (DIV_LAT > 1);
  localparam logic [CNT_W-1:0] MulCnt  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_LAT - 1);

`ifdef FORWARD_EN
  localparam int unsigned NumWr = 1;
`else
  localparam int unsigned NumWr = 3;
`endif

  ctrl_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLen-1:0]  target_q;

  logic                wr_valid [NumWr];
  logic                wr_wen   [NumWr];
  logic [RegAddrW-1:0] wr_dst   [NumWr];
  logic                src_use  [2];
  logic [RegAddrW-1:0] src_ra   [2];
  logic [2*NumWr-1:0]  hit;

  assign src_use[0] = d_use1;
  assign src_use[1] = d_use2;
  assign src_ra[0]  = d_ra1;
  assign src_ra[1]  = d_ra2;

`ifdef FORWARD_EN
  // Bypass covers everything except a load result that is not yet available.
  assign wr_valid[0] = e_valid & e_is_load;
  assign wr_wen[0]   = e_wen;
  assign wr_dst[0]   = e_dst;
  logic unused_fwd;
  assign unused_fwd = ^{m_wen, m_dst, w_valid, w_wen, w_dst};
`else
  // No bypass: every in-flight writer blocks until it has left WB.
  assign wr_valid[0] = e_valid;
  assign wr_wen[0]   = e_wen;
  assign wr_dst[0]   = e_dst;
  assign wr_valid[1] = m_valid;
  assign wr_wen[1]   = m_wen;
  assign wr_dst[1]   = m_dst;
  assign wr_valid[2] = w_valid;
  assign wr_wen[2]   = w_wen;
  assign wr_dst[2]   = w_dst;
  logic unused_ld;
  assign unused_ld = e_is_load;
`endif

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar w = 0; w < NumWr; w++) begin : g_wr
      pipeline_ctrl_raw_hazard_check u_chk (
        .use_i      (src_use[s]),
        .src_i      (src_ra[s]),
        .wr_valid_i (wr_valid[w]),
        .wr_wen_i   (wr_wen[w]),
        .wr_dst_i   (wr_dst[w]),
        .hit_o      (hit[s*NumWr+w])
      );
    end
  end

  logic in_run, trap_req, br_take, md_start, raw_stall;

  assign in_run    = (state_q == StRun);
  assign trap_req  = m_valid & (m_exception | m_mret) &
                     ((state_q == StRun) | (state_q == StMuldiv));
  // stall_e is never raised in RUN, so a taken branch there is always accepted.
  assign br_take   = in_run & ~trap_req & e_valid & e_br_taken;
  assign md_start  = in_run & ~trap_req & e_valid &
                     (e_is_div ? DivLong : (e_is_mul & MulLong));
  assign raw_stall = in_run & ~trap_req & ~br_take & d_valid & (|hit);

  // Sequencing FSM: trap redirection and mul/div occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      unique case (state_q)
        StRun, StMuldiv: begin
          if (trap_req) begin
            target_q <= m_exception ? trap_vec : mepc;
            cnt_q    <= '0;
            state_q  <= dbus_busy ? StTrapDrain : StTrapFlush;
          end else if (state_q == StRun) begin
            if (md_start) begin
              cnt_q   <= e_is_div ? DivCnt : MulCnt;
              state_q <= StMuldiv;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= StRun;
          end
        end
        StTrapDrain: if (!dbus_busy) state_q <= StTrapFlush;
        StTrapFlush: if (!ibus_busy) state_q <= StRun;
        default:     state_q <= StRun;
      endcase
    end
  end

  stage_ctrl_t ctrl_d, ctrl_e;

  assign stall_d = ctrl_d.stall;
  assign flush_d = ctrl_d.flush;
  assign stall_e = ctrl_e.stall;
  assign flush_e = ctrl_e.flush;

  // Per-stage stall/flush and redirect, by priority trap > branch > mul/div > RAW.
  always_comb begin
    stall_f        = 1'b0;
    ctrl_d         = '0;
    ctrl_e         = '0;
    flush_m        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    muldiv_busy    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StRun: begin
          if (br_take) begin
            redirect_valid = 1'b1;
            redirect_pc    = e_br_target;
            ctrl_d.flush   = 1'b1;
            ctrl_e.flush   = 1'b1;
          end else if (raw_stall) begin
            stall_f      = 1'b1;
            ctrl_d.stall = 1'b1;
            ctrl_e.flush = 1'b1;
          end
        end
        StMuldiv: begin
          if (!trap_req) begin
            stall_f      = 1'b1;
            ctrl_d.stall = 1'b1;
            ctrl_e.stall = 1'b1;
            flush_m      = 1'b1;
            muldiv_busy  = 1'b1;
          end
        end
        StTrapDrain: begin
          stall_f      = 1'b1;
          ctrl_d.stall = 1'b1;
          ctrl_e.stall = 1'b1;
        end
        StTrapFlush: begin
          ctrl_d.flush   = 1'b1;
          ctrl_e.flush   = 1'b1;
          flush_m        = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
        end
        default: ;
      endcase
    end
  end

endmodule
